// File: rtl/link_arbiter.sv
// Round-robin arbiter that lends one shared SEND/ACK link to N_REQ requesters.
// The peripheral ACK is asynchronous and reaches the FSM only through a 2-flop synchronizer.
module link_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk_arb,
  input  logic                    rst_arb,
  input  logic [N_REQ-1:0]        req_arb,
  input  logic [N_REQ*DATA_W-1:0] data_arb,
  output logic [N_REQ-1:0]        done_arb,
  output logic                    err_arb,
  output logic [N_REQ-1:0]        gnt_arb,
  output logic                    SEND_arb,
  output logic [DATA_W-1:0]       outData_arb,
  input  logic                    inACK_arb,
  output logic [1:0]              state_dbg
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SEND    = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]       state;
  logic [PTR_W-1:0] ptr;
  logic [15:0]      wait_cnt;
  logic [15:0]      cnt_inc;
  logic             timeout_hit;
  logic             ack_meta;
  logic             ack_s;
  logic             err_seen;
  logic             win_found;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] cand;

  assign state_dbg   = state;
  assign cnt_inc     = wait_cnt + 16'd1;
  assign timeout_hit = (cnt_inc == TO_LIMIT);

  // Four-phase link handshake: SEND_arb rises with outData_arb valid and held;
  // the peripheral raises ACK, SEND_arb drops, ACK falls, and only then is the transfer done.
  always_ff @(posedge clk_arb or negedge rst_arb) begin
    if (!rst_arb) begin
      ack_meta <= 1'b0;
      ack_s    <= 1'b0;
    end else begin
      ack_meta <= inACK_arb;
      ack_s    <= ack_meta;
    end
  end

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = PTR_W'((int'(ptr) + k) % N_REQ);
      if (!win_found && req_arb[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk_arb or negedge rst_arb) begin
    if (!rst_arb) begin
      state       <= S_IDLE;
      ptr         <= '0;
      wait_cnt    <= '0;
      err_seen    <= 1'b0;
      SEND_arb    <= 1'b0;
      outData_arb <= '0;
      gnt_arb     <= '0;
      done_arb    <= '0;
      err_arb     <= 1'b0;
    end else begin
      done_arb <= '0;
      err_arb  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (win_found) begin
            state       <= S_SEND;
            wait_cnt    <= '0;
            err_seen    <= 1'b0;
            gnt_arb     <= N_REQ'(1) << win_idx;
            outData_arb <= data_arb[int'(win_idx)*DATA_W +: DATA_W];
            SEND_arb    <= 1'b1;
            ptr         <= (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + 1'b1;
          end
        end
        S_SEND: begin
          if (ack_s) begin
            state    <= S_RELEASE;
            wait_cnt <= '0;
            SEND_arb <= 1'b0;
          end else if (timeout_hit) begin
            state    <= S_RELEASE;
            wait_cnt <= '0;
            SEND_arb <= 1'b0;
            err_arb  <= 1'b1;
            err_seen <= 1'b1;
          end else begin
            wait_cnt <= cnt_inc;
          end
        end
        S_RELEASE: begin
          if (!ack_s) begin
            state    <= S_DONE;
            wait_cnt <= '0;
            done_arb <= gnt_arb;
          end else if (timeout_hit) begin
            // A transfer that already flagged a SEND timeout is abandoned silently.
            state    <= S_IDLE;
            wait_cnt <= '0;
            gnt_arb  <= '0;
            err_arb  <= !err_seen;
          end else begin
            wait_cnt <= cnt_inc;
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          wait_cnt <= '0;
          gnt_arb  <= '0;
        end
        default: begin
          state    <= S_IDLE;
          wait_cnt <= '0;
          gnt_arb  <= '0;
          SEND_arb <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_link_arbiter.sv
// Directed and randomized checks of link_arbiter against a round-robin reference model.
module tb_link_arbiter;
  localparam int N_REQ   = 4;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;

  logic                    clk_arb = 1'b0;
  logic                    rst_arb = 1'b0;
  logic [N_REQ-1:0]        req_arb = '0;
  logic [N_REQ*DATA_W-1:0] data_arb = '0;
  logic [N_REQ-1:0]        done_arb;
  logic                    err_arb;
  logic [N_REQ-1:0]        gnt_arb;
  logic                    SEND_arb;
  logic [DATA_W-1:0]       outData_arb;
  logic                    inACK_arb = 1'b0;
  logic [1:0]              state_dbg;

  link_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_arb(clk_arb), .rst_arb(rst_arb), .req_arb(req_arb), .data_arb(data_arb),
    .done_arb(done_arb), .err_arb(err_arb), .gnt_arb(gnt_arb), .SEND_arb(SEND_arb),
    .outData_arb(outData_arb), .inACK_arb(inACK_arb), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk_arb = ~clk_arb;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int n_check = 0;
  int n_pass  = 0;
  logic [DATA_W-1:0] exp_q[$];
  int ptr_m = 0;
  logic [1:0] idle_code;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_check++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // reference: first requesting index found walking upward from the round-robin start
  function automatic int model_pick(input logic [N_REQ-1:0] req, input int from);
    for (int k = 0; k < N_REQ; k++)
      if (req[(from + k) % N_REQ]) return (from + k) % N_REQ;
    return -1;
  endfunction

  // drivers
  task automatic tick();
    @(posedge clk_arb);
    #1;
  endtask

  task automatic set_word(input int i, input logic [DATA_W-1:0] w);
    data_arb[i*DATA_W +: DATA_W] = w;
  endtask

  task automatic do_reset(input string tag);
    rst_arb   = 1'b0;
    req_arb   = '0;
    inACK_arb = 1'b0;
    #3;
    check({tag, "_rst_send"}, SEND_arb, 0);
    check({tag, "_rst_gnt"},  gnt_arb, 0);
    check({tag, "_rst_done"}, done_arb, 0);
    check({tag, "_rst_err"},  err_arb, 0);
    check({tag, "_rst_data"}, outData_arb, 0);
    @(negedge clk_arb);
    rst_arb = 1'b1;
    ptr_m   = 0;
    tick();
  endtask

  // One complete transfer with the peripheral raising ACK ack_dly cycles after SEND.
  task automatic xfer(input string tag, input logic [N_REQ-1:0] req, input int ack_dly);
    int w;
    int cyc;
    logic [DATA_W-1:0] exp_d;
    w = model_pick(req, ptr_m);
    ptr_m = (w + 1) % N_REQ;
    exp_q.push_back(data_arb[w*DATA_W +: DATA_W]);
    req_arb = req;
    tick();
    exp_d = exp_q.pop_front();
    check({tag, "_send"}, SEND_arb, 1);
    check({tag, "_gnt"},  gnt_arb, 1 << w);
    check({tag, "_data"}, outData_arb, exp_d);
    for (int d = 0; d < ack_dly; d++) begin
      tick();
      check({tag, "_hold"}, {SEND_arb, outData_arb}, {1'b1, exp_d});
    end
    inACK_arb = 1'b1;
    cyc = 0;
    while (SEND_arb === 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, "_ack_lat"}, cyc, 3);
    inACK_arb = 1'b0;
    cyc = 0;
    while (done_arb === '0 && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, "_rel_lat"}, cyc, 3);
    check({tag, "_done"}, done_arb, 1 << w);
    check({tag, "_noerr"}, err_arb, 0);
    tick();
    check({tag, "_end"}, {gnt_arb, done_arb}, 0);
    check({tag, "_idle"}, state_dbg, idle_code);
  endtask

  int cyc;
  int w;
  logic done_seen;

  initial begin
    #1;
    idle_code = state_dbg;
    do_reset("boot");

    // single requester, ACK three cycles after SEND
    set_word(0, 32'hA5A5_0001);
    xfer("single", 4'b0001, 3);

    // all requesters held: strict rotation 0,1,2,3,0
    do_reset("rr");
    for (int i = 0; i < N_REQ; i++) set_word(i, 32'h1000_0000 + i);
    for (int i = 0; i < 5; i++) xfer($sformatf("rr%0d", i), 4'b1111, 1);

    // ACK never rises: SEND timeout, then normal release gives done
    w = model_pick(4'b0100, ptr_m);
    ptr_m = (w + 1) % N_REQ;
    req_arb = 4'b0100;
    tick();
    check("to_send", SEND_arb, 1);
    cyc = 0;
    while (err_arb !== 1'b1 && cyc < 30) begin
      tick();
      cyc++;
    end
    check("to_err_lat", cyc, TIMEOUT);
    check("to_send_low", SEND_arb, 0);
    check("to_gnt_kept", gnt_arb, 1 << w);
    tick();
    check("to_done", done_arb, 1 << w);
    check("to_err_once", err_arb, 0);
    tick();
    check("to_end", {gnt_arb, done_arb, err_arb}, 0);
    req_arb = '0;

    // ACK stuck high after SEND drops: release timeout, no done
    w = model_pick(4'b1000, ptr_m);
    ptr_m = (w + 1) % N_REQ;
    req_arb = 4'b1000;
    tick();
    check("stuck_gnt", gnt_arb, 1 << w);
    inACK_arb = 1'b1;
    cyc = 0;
    while (SEND_arb === 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    check("stuck_ack_lat", cyc, 3);
    cyc = 0;
    done_seen = 1'b0;
    while (err_arb !== 1'b1 && cyc < 30) begin
      tick();
      cyc++;
      done_seen = done_seen | (|done_arb);
    end
    req_arb = '0;
    check("stuck_err_lat", cyc, TIMEOUT);
    check("stuck_gnt_clr", gnt_arb, 0);
    check("stuck_no_done", done_seen, 0);
    // ACK still high while idle must not start anything
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_ack_ignored", {SEND_arb, gnt_arb, err_arb, done_arb}, 0);
    end
    inACK_arb = 1'b0;
    repeat (3) tick();

    // ACK changed between edges: two-flop delay before the FSM reacts
    set_word(0, 32'hC0DE_0000);
    w = model_pick(4'b0001, ptr_m);
    ptr_m = (w + 1) % N_REQ;
    req_arb = 4'b0001;
    tick();
    check("async_gnt", gnt_arb, 1 << w);
    @(negedge clk_arb);
    inACK_arb = 1'b1;
    tick();
    check("async_rise_e1", SEND_arb, 1);
    tick();
    check("async_rise_e2", SEND_arb, 1);
    tick();
    check("async_rise_e3", SEND_arb, 0);
    @(negedge clk_arb);
    inACK_arb = 1'b0;
    tick();
    check("async_fall_e1", done_arb, 0);
    tick();
    check("async_fall_e2", done_arb, 0);
    tick();
    check("async_fall_e3", done_arb, 1 << w);
    req_arb = '0;
    tick();

    // reset mid-SEND after the pointer has moved away from 0
    for (int i = 0; i < N_REQ; i++) set_word(i, 32'hBEEF_0000 + i);
    xfer("pre_rst", 4'b0010, 0);
    w = model_pick(4'b0100, ptr_m);
    req_arb = 4'b0100;
    tick();
    check("mid_gnt", gnt_arb, 1 << w);
    tick();
    rst_arb = 1'b0;
    #2;
    check("mid_rst_outs", {SEND_arb, gnt_arb, done_arb, err_arb}, 0);
    check("mid_rst_data", outData_arb, 0);
    req_arb = '0;
    #2;
    rst_arb = 1'b1;
    ptr_m = 0;
    xfer("post_rst", 4'b1010, 2);

    // randomized traffic against the model
    for (int t = 0; t < 16; t++) begin
      for (int i = 0; i < N_REQ; i++) set_word(i, $urandom);
      xfer($sformatf("rnd%0d", t), N_REQ'($urandom_range(1, (1 << N_REQ) - 1)), $urandom_range(0, 4));
    end

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule

// File: doc/link_arbiter.md
LINK_ARBITER -- requirements
Module: link_arbiter

Interface
REQ-001 The module SHALL have parameter N_REQ, default 4, meaning the number of requesters (2..8).
REQ-002 The module SHALL have parameter DATA_W, default 32, meaning the transfer word width.
REQ-003 The module SHALL have parameter TIMEOUT, default 255, meaning the maximum cycles to wait on one ACK edge (1..65535).
REQ-004 The module SHALL have port clk_arb, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port rst_arb, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-006 The module SHALL have port req_arb, input, N_REQ bits: per-requester transfer request, level, held until that requester's done.
REQ-007 The module SHALL have port data_arb, input, N_REQ*DATA_W bits: per-requester word; requester i at bits [i*DATA_W +: DATA_W].
REQ-008 The module SHALL have port done_arb, output, N_REQ bits: one-cycle pulse, transfer of requester i completed.
REQ-009 The module SHALL have port err_arb, output, 1 bit: one-cycle pulse, handshake timeout on the current transfer.
REQ-010 The module SHALL have port gnt_arb, output, N_REQ bits: one-hot owner of the link, all zero when idle.
REQ-011 The module SHALL have port SEND_arb, output, 1 bit: SEND to the peripheral, registered.
REQ-012 The module SHALL have port outData_arb, output, DATA_W bits: word to the peripheral, registered, stable while SEND_arb=1.
REQ-013 The module SHALL have port inACK_arb, input, 1 bit: the peripheral ACK, asynchronous to clk_arb.

Function
REQ-014 The module SHALL pass inACK_arb through a 2-flop synchronizer; ack_s below is its output, and all FSM decisions SHALL use only ack_s.
REQ-015 The FSM SHALL have states IDLE, SEND, RELEASE, DONE.
REQ-016 In IDLE with any req_arb bit set, the module SHALL select the winner by round-robin starting from pointer ptr, then load gnt_arb, outData_arb and SEND_arb=1 on the same edge, and move to SEND.
REQ-017 Grant latency SHALL be 1 cycle: if req is sampled at edge k, SEND_arb is high after edge k.
REQ-018 After each grant to requester i, ptr SHALL become (i+1) mod N_REQ; ptr SHALL not change otherwise.
REQ-019 In SEND, when ack_s=1, the module SHALL set SEND_arb=0 and move to RELEASE.
REQ-020 In RELEASE, when ack_s=0, the module SHALL move to DONE.
REQ-021 In DONE (one cycle), done_arb[i] SHALL equal 1 for the granted i; gnt_arb SHALL clear on leaving DONE, and the state SHALL return to IDLE.
REQ-022 Requests SHALL not be evaluated in SEND, RELEASE or DONE; the minimum back-to-back spacing is therefore one IDLE cycle.
REQ-023 A wait counter, DATA_W-independent and 16 bits wide, SHALL clear on every state entry and increment each cycle in SEND or RELEASE.
REQ-024 On counter reaching TIMEOUT in SEND, the module SHALL pulse err_arb, set SEND_arb=0 and move to RELEASE.
REQ-025 On counter reaching TIMEOUT in RELEASE, the module SHALL pulse err_arb, clear gnt_arb and move to IDLE with no done pulse.
REQ-026 Only one err_arb pulse SHALL occur per transfer; a SEND-timeout followed by normal RELEASE completion SHALL produce a done pulse as well.
REQ-027 A req_arb bit dropping during a granted transfer SHALL not abort the transfer.
REQ-028 ack_s=1 observed in IDLE SHALL be ignored, with no grant forced.

Reset
REQ-029 While rst_arb=0, the module SHALL force state=IDLE, ptr=0, counter=0, synchronizer flops=0, SEND_arb=0, outData_arb=0, gnt_arb=0, done_arb=0, err_arb=0 immediately, independent of clk_arb.
REQ-030 Reset asserted mid-transfer SHALL drop SEND_arb at once; after release, the first grant SHALL follow the ptr=0 priority.

Verification
REQ-031 The bench SHALL cover: req_arb=0001, data0=32'hA5A5_0001, peripheral ACKs 3 cycles after SEND -> SEND_arb high next cycle, outData_arb=A5A5_0001, done_arb=0001 once, gnt_arb returns to 0.
REQ-032 The bench SHALL cover: req_arb=1111 held, every requester re-requesting -> grant order 0,1,2,3,0, each done once per grant.
REQ-033 The bench SHALL cover: TIMEOUT=8, ACK never rises -> err_arb pulse 8 cycles after SEND entry, SEND_arb=0, ack_s low -> done pulse, no hang.
REQ-034 The bench SHALL cover: ACK stuck high after SEND drops, TIMEOUT=8 -> err_arb pulse, IDLE, no done pulse.
REQ-035 The bench SHALL cover: rst_arb pulsed low mid-SEND -> all outputs 0 asynchronously; after release, req_arb=1010 -> requester 1 granted first.
REQ-036 The bench SHALL cover: inACK_arb toggled between clock edges -> FSM advances no earlier than 2 edges after the ACK change.
